stopwatch_sec_min_ctrl: RTL and testbench

- Stage directly downstream of the centisecond BCD counter in the stopwatch path.
- Consumes the centisecond digits and the per-second rollover toggle, and counts BCD seconds and minutes.
- Runs the start/pause/clear/lap control FSM and drives the 16-bit BCD display word to the 7-segment scanner.
- Returns run_en and cnt_clr upstream, so the centisecond counter is gated and cleared by this block.

---
 rtl/stopwatch_sec_min_ctrl.sv | 173 +++++++++++++++++
 tb/tb_stopwatch_sec_min_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_sec_min_ctrl.sv
// Seconds/minutes BCD stage and start/pause/clear/lap control for the stopwatch.
// Define STOPWATCH_BLINK_EN to drive dp_out from the centisecond phase.
module stopwatch_sec_min_ctrl #(
   parameter logic [7:0] MIN_MAX     = 8'h59,
   parameter bit         HOLD_ON_OVF = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        btn_start,
   input  logic        btn_lap,
   input  logic        btn_clear,
   input  logic [7:0]  cs_bcd,
   input  logic        cs_carry_tgl,
   output logic        run_en,
   output logic        cnt_clr,
   output logic [15:0] disp_bcd,
   output logic        lap_active,
   output logic        ovf,
   output logic        dp_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE
   } state_e;

   state_e      state_q, state_d;
   logic        start_q, lap_q, clear_q, tgl_q;
   logic [7:0]  sec_q, sec_d;
   logic [7:0]  min_q, min_d;
   logic        ovf_q, ovf_d;
   logic        lap_q2, lap_d;
   logic [15:0] snap_q, snap_d;
   logic [15:0] disp_q, disp_d;
   logic        run_q, clr_q, clr_d;

   logic        start_rise, lap_rise, clear_rise, carry_evt;
   logic        count;
   logic [15:0] live;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [3:0] tens;
      if (v[3:0] == 4'd9) begin
         tens = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
         return {tens, 4'd0};
      end
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign start_rise = btn_start & ~start_q;
   assign lap_rise   = btn_lap & ~lap_q;
   assign clear_rise = btn_clear & ~clear_q;
   assign carry_evt  = cs_carry_tgl ^ tgl_q;

   assign live = (min_q == 8'h00) ? {sec_q, cs_bcd}
                                  : {min_q, sec_q};

   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      min_d   = min_q;
      ovf_d   = ovf_q;
      lap_d   = lap_q2;
      snap_d  = snap_q;
      clr_d   = 1'b0;
      count   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_rise) state_d = S_RUN;
         end
         S_RUN: begin
            count = carry_evt;
            if (start_rise) begin
               state_d = S_PAUSE;
            end else if (lap_rise) begin
               lap_d = ~lap_q2;
               if (!lap_q2) snap_d = live;
            end
         end
         S_PAUSE: begin
            if (clear_rise) begin
               state_d = S_IDLE;
               clr_d   = 1'b1;
               sec_d   = 8'h00;
               min_d   = 8'h00;
               ovf_d   = 1'b0;
               lap_d   = 1'b0;
            end else if (start_rise) begin
               state_d = S_RUN;
            end else if (lap_rise) begin
               lap_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Counting happens only in RUN, so it never collides with clear.
      if (count) begin
         if (min_q == MIN_MAX && sec_q == 8'h59) begin
            ovf_d = 1'b1;
            if (!HOLD_ON_OVF) begin
               sec_d = 8'h00;
               min_d = 8'h00;
            end
         end else if (sec_q == 8'h59) begin
            sec_d = 8'h00;
            min_d = bcd_inc(min_q);
         end else begin
            sec_d = bcd_inc(sec_q);
         end
      end
      disp_d = lap_d ? snap_d : live;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         lap_q   <= 1'b0;
         clear_q <= 1'b0;
         tgl_q   <= 1'b0;
         sec_q   <= 8'h00;
         min_q   <= 8'h00;
         ovf_q   <= 1'b0;
         lap_q2  <= 1'b0;
         snap_q  <= 16'h0000;
         disp_q  <= 16'h0000;
         run_q   <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= btn_start;
         lap_q   <= btn_lap;
         clear_q <= btn_clear;
         tgl_q   <= cs_carry_tgl;
         sec_q   <= sec_d;
         min_q   <= min_d;
         ovf_q   <= ovf_d;
         lap_q2  <= lap_d;
         snap_q  <= snap_d;
         disp_q  <= disp_d;
         run_q   <= (state_d == S_RUN);
         clr_q   <= clr_d;
      end
   end

`ifdef STOPWATCH_BLINK_EN
   logic dp_q, dp_d, cs_low;

   assign cs_low = (cs_bcd < 8'h50);

   always_comb begin
      dp_d = 1'b1;
      if (state_d == S_RUN) dp_d = lap_d ? ~cs_low : cs_low;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dp_q <= 1'b1;
      else          dp_q <= dp_d;
   end

   assign dp_out = dp_q;
`else
   assign dp_out = 1'b1;
`endif

   assign run_en     = run_q;
   assign cnt_clr    = clr_q;
   assign disp_bcd   = disp_q;
   assign lap_active = lap_q2;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_sec_min_ctrl.sv
// Bench for stopwatch_sec_min_ctrl: vector table, corner sequences, random ops
// against an elapsed-seconds model; second instance wraps at 01:59.
module tb_stopwatch_sec_min_ctrl;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
   logic cs_carry_tgl = 1'b0;
   logic [7:0] cs_bcd = 8'h00;

   logic a_run, a_clr, a_lap, a_ovf, a_dp;
   logic b_run, b_clr, b_lap, b_ovf, b_dp;
   logic [15:0] a_disp, b_disp;

   int checks = 0;
   int errors = 0;

   stopwatch_sec_min_ctrl u_a (
      .clk(clk), .reset_n(reset_n),
      .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
      .cs_bcd(cs_bcd), .cs_carry_tgl(cs_carry_tgl),
      .run_en(a_run), .cnt_clr(a_clr), .disp_bcd(a_disp),
      .lap_active(a_lap), .ovf(a_ovf), .dp_out(a_dp)
   );

   stopwatch_sec_min_ctrl #(.MIN_MAX(8'h01), .HOLD_ON_OVF(1'b0)) u_b (
      .clk(clk), .reset_n(reset_n),
      .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
      .cs_bcd(cs_bcd), .cs_carry_tgl(cs_carry_tgl),
      .run_en(b_run), .cnt_clr(b_clr), .disp_bcd(b_disp),
      .lap_active(b_lap), .ovf(b_ovf), .dp_out(b_dp)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: elapsed seconds as plain integers
   int m_st;
   int ta, tb;
   bit oa, ob, ml;
   logic [15:0] sa, sb;

   function automatic logic [7:0] bcd8(input int n);
      return 8'((n / 10) * 16 + (n % 10));
   endfunction

   function automatic logic [15:0] live(input int t, input logic [7:0] cs);
      int m, s;
      m = t / 60;
      s = t % 60;
      return (m == 0) ? {bcd8(s), cs} : {bcd8(m), bcd8(s)};
   endfunction

   task automatic minc(inout int t, inout bit o, input int lim, input bit hold);
      if (t == lim) begin
         o = 1'b1;
         if (!hold) t = 0;
      end else begin
         t++;
      end
   endtask

   function automatic logic exp_dp(input int st, input bit lp,
                                   input logic [7:0] cs);
`ifdef STOPWATCH_BLINK_EN
      if (st == 1) return lp ? !(cs < 8'h50) : (cs < 8'h50);
      return 1'b1;
`else
      return 1'b1;
`endif
   endfunction

   typedef struct {
      bit          st, lp, cl;
      int          ntgl;
      logic [7:0]  cs;
      bit          e_run, e_lap;
      logic [15:0] e_disp;
   } vec_t;

   vec_t tbl[15];

   task automatic apply_vec(input vec_t v);
      cs_bcd = v.cs;
      repeat (v.ntgl) begin
         cs_carry_tgl = ~cs_carry_tgl;
         step();
      end
      btn_start = v.st;
      btn_lap   = v.lp;
      btn_clear = v.cl;
      step();
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      btn_clear = 1'b0;
      step();
      step();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_run"}, a_run, 0);
      chk({tag, "_clr"}, a_clr, 0);
      chk({tag, "_disp"}, a_disp, 16'h0000);
      chk({tag, "_lap"}, a_lap, 0);
      chk({tag, "_ovf"}, a_ovf, 0);
      chk({tag, "_dp"}, a_dp, 1);
   endtask

   initial begin
      tbl[0]  = '{1, 0, 0, 0,  8'h00, 1, 0, 16'h0000};
      tbl[1]  = '{0, 0, 0, 3,  8'h00, 1, 0, 16'h0300};
      tbl[2]  = '{0, 0, 0, 0,  8'h47, 1, 0, 16'h0347};
      tbl[3]  = '{0, 0, 0, 9,  8'h34, 1, 0, 16'h1234};
      tbl[4]  = '{0, 1, 0, 0,  8'h34, 1, 1, 16'h1234};
      tbl[5]  = '{0, 0, 0, 5,  8'h34, 1, 1, 16'h1234};
      tbl[6]  = '{0, 1, 0, 0,  8'h34, 1, 0, 16'h1734};
      tbl[7]  = '{0, 0, 0, 42, 8'h34, 1, 0, 16'h5934};
      tbl[8]  = '{0, 0, 0, 1,  8'h34, 1, 0, 16'h0100};
      tbl[9]  = '{0, 0, 1, 0,  8'h34, 1, 0, 16'h0100};
      tbl[10] = '{1, 0, 0, 0,  8'h34, 0, 0, 16'h0100};
      tbl[11] = '{0, 0, 0, 2,  8'h34, 0, 0, 16'h0100};
      tbl[12] = '{0, 1, 0, 0,  8'h34, 0, 0, 16'h0100};
      tbl[13] = '{1, 0, 0, 0,  8'h34, 1, 0, 16'h0100};
      tbl[14] = '{0, 0, 0, 1,  8'h34, 1, 0, 16'h0101};

      step();
      step();
      chk_reset("rst");
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 15; i++) begin
         apply_vec(tbl[i]);
         chk($sformatf("vec%0d_run", i), a_run, tbl[i].e_run);
         chk($sformatf("vec%0d_lap", i), a_lap, tbl[i].e_lap);
         chk($sformatf("vec%0d_disp", i), a_disp, tbl[i].e_disp);
      end

      // start and lap together in RUN with lap frozen: pause wins
      btn_lap = 1'b1;
      step();
      btn_lap = 1'b0;
      chk("frz_lap", a_lap, 1);
      step();
      btn_start = 1'b1;
      btn_lap   = 1'b1;
      step();
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      chk("sl_run", a_run, 0);
      chk("sl_lap", a_lap, 1);
      cs_carry_tgl = ~cs_carry_tgl;
      step();
      step();
      chk("sl_disp", a_disp, 16'h0101);
      btn_lap = 1'b1;
      step();
      btn_lap = 1'b0;
      chk("rel_lap", a_lap, 0);
      step();
      chk("rel_disp", a_disp, 16'h0101);

      // clear and start together in PAUSE: clear wins
      btn_clear = 1'b1;
      btn_start = 1'b1;
      step();
      btn_clear = 1'b0;
      btn_start = 1'b0;
      chk("clr_pulse", a_clr, 1);
      chk("clr_run", a_run, 0);
      step();
      chk("clr_pulse_end", a_clr, 0);
      chk("clr_disp", a_disp, 16'h0034);
      chk("clr_ovf_b", b_ovf, 0);

      // overflow: A holds at 59:59, B wraps past 01:59
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      repeat (3599) begin
         cs_carry_tgl = ~cs_carry_tgl;
         step();
      end
      step();
      chk("pre_ovf_disp", a_disp, 16'h5959);
      chk("pre_ovf_a", a_ovf, 0);
      chk("pre_ovf_disp_b", b_disp, 16'h0159);
      chk("pre_ovf_b", b_ovf, 1);
      cs_carry_tgl = ~cs_carry_tgl;
      step();
      step();
      chk("hold_disp", a_disp, 16'h5959);
      chk("hold_ovf", a_ovf, 1);
      chk("wrap_disp", b_disp, 16'h0034);
      chk("wrap_ovf", b_ovf, 1);

      // asynchronous reset between edges
      @(posedge clk);
      #4 reset_n = 1'b0;
      #1 chk_reset("async");
      #2 reset_n = 1'b1;

      m_st = 0;
      ta = 0;
      tb = 0;
      oa = 0;
      ob = 0;
      ml = 0;
      sa = 16'h0;
      sb = 16'h0;
      step();

      for (int i = 0; i < 300; i++) begin
         int r;
         logic [15:0] ea, eb;
         logic ed;
         r = $urandom_range(0, 99);
         if (r < 55) begin
            cs_carry_tgl = ~cs_carry_tgl;
            step();
            if (m_st == 1) begin
               minc(ta, oa, 59 * 60 + 59, 1'b1);
               minc(tb, ob, 1 * 60 + 59, 1'b0);
            end
         end else if (r < 70) begin
            btn_start = 1'b1;
            step();
            btn_start = 1'b0;
            m_st = (m_st == 1) ? 2 : 1;
         end else if (r < 80) begin
            btn_lap = 1'b1;
            step();
            btn_lap = 1'b0;
            if (m_st == 1 && !ml) begin
               ml = 1;
               sa = live(ta, cs_bcd);
               sb = live(tb, cs_bcd);
            end else if (m_st != 0) begin
               ml = 0;
            end
         end else if (r < 90) begin
            btn_clear = 1'b1;
            step();
            btn_clear = 1'b0;
            if (m_st == 2) begin
               m_st = 0;
               ta = 0;
               tb = 0;
               oa = 0;
               ob = 0;
               ml = 0;
            end
         end else begin
            cs_bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            step();
         end
         step();
         step();
         ea = ml ? sa : live(ta, cs_bcd);
         eb = ml ? sb : live(tb, cs_bcd);
         ed = exp_dp(m_st, ml, cs_bcd);
         checks++;
         if (a_run !== (m_st == 1) || a_lap !== ml || a_ovf !== oa ||
             b_ovf !== ob || a_disp !== ea || b_disp !== eb ||
             a_clr !== 1'b0 || a_dp !== ed) begin
            errors++;
            $display("FAIL rand%0d actual run=%b lap=%b ovf=%b/%b disp=%h/%h clr=%b dp=%b required run=%b lap=%b ovf=%b/%b disp=%h/%h clr=0 dp=%b",
                     i, a_run, a_lap, a_ovf, b_ovf, a_disp, b_disp, a_clr,
                     a_dp, (m_st == 1), ml, oa, ob, ea, eb, ed);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
